// File: rtl/sort_pkg.sv
// sort_pkg
// Types and constants shared by the selection sorter and its result
// streamer: the streamer state enum and the depth of the return buffer.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sort_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2
// Two-entry synchronous FIFO that absorbs RAM read latency against
// consumer backpressure. The head entry is always presented on `head`.
// The head comes straight from a storage register, so there is no path
// from pop to head.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous flush (pointers and count only)
//   push, din    write din at the tail
//   pop          drop the head entry
//   head         current head entry
//   count        number of valid entries (0..2)
module stream_fifo2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_sel;
  logic             rd_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_sel] <= din;
        wr_sel      <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_sel];

endmodule

// File: rtl/sort_result_streamer.sv
// sort_result_streamer
// Reads elements 0..i_num_elems from the sorter RAM over a synchronous
// read port and emits them in address order as a valid/ready stream.
// A 2-entry return buffer lets it sustain one element per cycle under
// backpressure.
// Build option: define SORT_ORDER_CHECK_EN to add a sticky flag that
// reports any element smaller than its predecessor in the stream.
// Without it, o_order_err is tied low.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start, i_num_elems   start pulse and index of last element
//   o_rd_en, o_rd_addr     RAM read request
//   i_rd_data              RAM data, one cycle after o_rd_en
//   o_data, o_valid,
//   i_ready, o_last        output stream
//   o_busy, o_done         status
//   o_order_err            sticky order-violation flag
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing reads
// DRAIN  | all reads issued, waiting for the buffer to empty
// DONE   | one-cycle completion pulse
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int SIZE_ADDR = 4,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_rd_addr,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_order_err
);

  sort_state_t          state, state_nxt;
  logic [SIZE_ADDR-1:0] last_idx;
  // One bit wider than the address so a full-RAM stream ends without wrap.
  logic [SIZE_ADDR:0]   rd_ptr;
  logic                 inflight;
  logic                 inflight_last;
  logic                 start_acc;
  logic                 issue;
  logic                 issue_last;
  logic                 pop;
  logic [1:0]           fifo_count;
  logic [SIZE_DATA:0]   fifo_head;
  logic [2:0]           occupancy;

  assign start_acc = i_start && (state == IDLE);
  assign pop       = o_valid && i_ready;

  // Entries held or already committed by outstanding reads after this
  // cycle's pop; a pop can only happen when count >= 1, so no underflow.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == STREAM) && (rd_ptr <= {1'b0, last_idx}) &&
                      (occupancy < 3'(FIFO_DEPTH));
  assign issue_last = issue && (rd_ptr == {1'b0, last_idx});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      last_idx      <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (start_acc) begin
        last_idx <= i_num_elems;
        rd_ptr   <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = STREAM;
      STREAM:  if (issue_last) state_nxt = DRAIN;
      // The last element is also the last read, so when it leaves the
      // buffer nothing remains in flight or stored.
      DRAIN:   if (pop && fifo_head[SIZE_DATA]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  stream_fifo2 #(
    .WIDTH (SIZE_DATA + 1)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (start_acc),
    .push  (inflight),
    .din   ({inflight_last, i_rd_data}),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign o_rd_en   = issue;
  assign o_rd_addr = issue ? rd_ptr[SIZE_ADDR-1:0] : '0;
  assign o_valid   = (fifo_count != 2'd0);
  assign o_data    = fifo_head[SIZE_DATA-1:0];
  // The head register keeps its last-bit after the final pop; gate it.
  assign o_last    = o_valid && fifo_head[SIZE_DATA];
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);

`ifdef SORT_ORDER_CHECK_EN
  logic [SIZE_DATA-1:0] prev_data;
  logic                 have_prev;
  logic                 order_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_data <= '0;
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (start_acc) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (pop) begin
      if (have_prev && (o_data < prev_data)) begin
        order_err <= 1'b1;
      end
      prev_data <= o_data;
      have_prev <= 1'b1;
    end
  end

  assign o_order_err = order_err;
`else
  assign o_order_err = 1'b0;
`endif

endmodule
